jpeg_quant_pipe: RTL and testbench

Pipelined, multi-lane JPEG quantizer that replaces the single-coefficient combinational multiply-and-shift quantizer. It multiplies DCT coefficients by per-position reciprocals from an internal 64-entry table, with 2-stage registered arithmetic, valid/ready flow control, optional rounding and output saturation. It sits between the DCT output buffer and the zig-zag/entropy stage of the JPEG accelerator.

---
 rtl/jpeg_quant_pkg.sv | 35 +++
 rtl/jpeg_quant_lane.sv | 84 ++++++++
 rtl/jpeg_quant_pipe.sv | 125 ++++++++++++
 tb/tb_jpeg_quant_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_quant_pkg.sv
// ============================================================================
// Module      : jpeg_quant_pkg
// Description : Shared constants and helpers for the pipelined JPEG quantizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jpeg_quant_pkg;

    localparam int BLOCK_SIZE = 64;
    localparam int POS_W      = 6;

    // Reciprocal value representing 1.0 with the given number of fraction bits.
    function automatic logic [31:0] rec_one(input int unsigned shift);
        rec_one = 32'd1 << shift;
    endfunction

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned w);
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (w - 1));
        if (v > maxv)
            sat_signed = maxv;
        else if (v < minv)
            sat_signed = minv;
        else
            sat_signed = v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jpeg_quant_lane.sv
// ============================================================================
// Module      : jpeg_quant_lane
// Description : One lane of the quantizer: abs/sign capture, multiply by the
//               reciprocal, optional rounding (JPEG_QUANT_ROUND_EN), shift and
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jpeg_quant_lane
    import jpeg_quant_pkg::*;
#(
    parameter int DW    = 16,
    parameter int RW    = 16,
    parameter int SHIFT = 14,
    parameter int OW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_s1_load,
    input  logic          i_s2_load,
    input  logic [DW-1:0] i_x,
    input  logic [RW-1:0] i_rec,
    output logic [OW-1:0] o_q
);

    // One spare bit on top of the product keeps the rounding add from wrapping.
    localparam int c_PW = DW + RW + 2;

    logic [DW:0]      w_xe;
    logic             w_neg;
    logic [DW:0]      w_abs;

    logic [DW:0]      r_abs;
    logic             r_sign;
    logic [RW-1:0]    r_rec;
    logic [OW-1:0]    r_q;

    logic [c_PW-1:0]  w_prod;
    logic [c_PW-1:0]  w_sum;
    logic [c_PW-1:0]  w_mag;
    logic signed [63:0] w_sval;
    logic [OW-1:0]    w_q;

    assign w_xe  = {i_x[DW-1], i_x};
    assign w_neg = i_x[DW-1];
    assign w_abs = w_neg ? ((~w_xe) + {{DW{1'b0}}, 1'b1}) : w_xe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_abs  <= '0;
            r_sign <= 1'b0;
            r_rec  <= '0;
        end else if (i_s1_load) begin
            r_abs  <= w_abs;
            r_sign <= w_neg;
            r_rec  <= i_rec;
        end
    end

    assign w_prod = c_PW'(r_abs) * c_PW'(r_rec);

`ifdef JPEG_QUANT_ROUND_EN
    assign w_sum = w_prod + (c_PW'(1) << (SHIFT - 1));
`else
    assign w_sum = w_prod;
`endif

    assign w_mag  = w_sum >> SHIFT;
    assign w_sval = r_sign ? -$signed(64'(w_mag)) : $signed(64'(w_mag));
    assign w_q    = OW'(sat_signed(w_sval, OW));

    always_ff @(posedge clk) begin
        if (rst)
            r_q <= '0;
        else if (i_s2_load)
            r_q <= w_q;
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/jpeg_quant_pipe.sv
// ============================================================================
// Module      : jpeg_quant_pipe
// Description : Multi-lane, 2-stage JPEG quantizer with reciprocal table,
//               block position counter and valid/ready handshake. Rounding is
//               enabled by defining JPEG_QUANT_ROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jpeg_quant_pipe
    import jpeg_quant_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int RW    = 16,
    parameter int SHIFT = 14,
    parameter int OW    = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [LANES*DW-1:0]   x_i,
    input  logic                  blk_clr_i,
    input  logic                  tbl_we_i,
    input  logic [POS_W-1:0]      tbl_addr_i,
    input  logic [RW-1:0]         tbl_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES*OW-1:0]   q_o,
    output logic                  out_last_o
);

    localparam logic [RW-1:0]    c_REC_ONE = RW'(rec_one(SHIFT));
    localparam logic [POS_W-1:0] c_LANES   = POS_W'(LANES);

    logic [POS_W-1:0] r_pos;
    logic [RW-1:0]    r_tbl [BLOCK_SIZE];
    logic             r_s1_valid;
    logic             r_s1_last;
    logic             r_s2_valid;
    logic             r_s2_last;

    logic             w_adv2;
    logic             w_accept;
    logic             w_s2_load;
    logic [POS_W-1:0] w_base;
    logic             w_last;

    assign w_adv2     = ~r_s2_valid | out_ready_i;
    assign in_ready_o = w_adv2 | ~r_s1_valid;
    assign w_accept   = in_valid_i & in_ready_o;
    assign w_s2_load  = w_adv2 & r_s1_valid;

    // A clear on the accepting cycle forces this beat to start the block.
    assign w_base = blk_clr_i ? '0 : r_pos;
    assign w_last = ({1'b0, w_base} + {1'b0, c_LANES}) == (POS_W + 1)'(BLOCK_SIZE);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_pos <= '0;
        else if (w_accept)
            r_pos <= w_base + c_LANES;
        else if (blk_clr_i)
            r_pos <= '0;
    end

    // Lanes read the pre-edge table contents, so a same-edge write is not seen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BLOCK_SIZE; i++)
                r_tbl[i] <= c_REC_ONE;
        end else if (tbl_we_i) begin
            r_tbl[tbl_addr_i] <= tbl_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_last  <= w_last;
            end else if (w_adv2) begin
                r_s1_valid <= 1'b0;
            end
            if (w_adv2)
                r_s2_valid <= r_s1_valid;
            if (w_s2_load)
                r_s2_last <= r_s1_last;
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [POS_W-1:0] w_addr;
            assign w_addr = w_base + POS_W'(k);

            jpeg_quant_lane #(
                .DW    (DW),
                .RW    (RW),
                .SHIFT (SHIFT),
                .OW    (OW)
            ) u_lane (
                .clk       (clk_i),
                .rst       (rst_i),
                .i_s1_load (w_accept),
                .i_s2_load (w_s2_load),
                .i_x       (x_i[k*DW +: DW]),
                .i_rec     (r_tbl[w_addr]),
                .o_q       (q_o[k*OW +: OW])
            );
        end
    endgenerate

    assign out_valid_o = r_s2_valid;
    assign out_last_o  = r_s2_last;

endmodule

`default_nettype wire

// File: tb/tb_jpeg_quant_pipe.sv
// ============================================================================
// Module      : tb_jpeg_quant_pipe
// Description : Directed self-checking bench for jpeg_quant_pipe (both the
//               truncating and the JPEG_QUANT_ROUND_EN build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jpeg_quant_pipe;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int RW    = 16;
    localparam int SHIFT = 14;
    localparam int OW    = 12;

`ifdef JPEG_QUANT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] x;
    logic                blk_clr;
    logic                tbl_we;
    logic [5:0]          tbl_addr;
    logic [RW-1:0]       tbl_data;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*OW-1:0] q;
    logic                out_last;

    jpeg_quant_pipe #(
        .LANES (LANES), .DW (DW), .RW (RW), .SHIFT (SHIFT), .OW (OW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .x_i         (x),
        .blk_clr_i   (blk_clr),
        .tbl_we_i    (tbl_we),
        .tbl_addr_i  (tbl_addr),
        .tbl_data_i  (tbl_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .q_o         (q),
        .out_last_o  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [LANES*OW-1:0] qv;
        logic                last;
    } out_t;
    out_t oq[$];

    always @(negedge clk)
        if (!rst && out_valid && out_ready)
            oq.push_back('{q, out_last});

    typedef struct {
        int x;
        int rec;
        int exp_t;
        int exp_r;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lane_q(input logic [LANES*OW-1:0] v, input int k);
        logic signed [OW-1:0] t;
        t = v[k*OW +: OW];
        return int'(t);
    endfunction

    function automatic logic [LANES*DW-1:0] pack_all(input int v);
        logic [LANES*DW-1:0] r;
        for (int k = 0; k < LANES; k++)
            r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic int seq_x(input int i, input int k);
        return i * 37 - 100 + k * 5;
    endfunction

    function automatic logic [LANES*DW-1:0] pack_seq(input int i);
        logic [LANES*DW-1:0] r;
        for (int k = 0; k < LANES; k++)
            r[k*DW +: DW] = DW'(seq_x(i, k));
        return r;
    endfunction

    // All tasks start and return one time unit after a rising edge.
    task automatic tbl_write(input int a, input int d);
        tbl_we   = 1'b1;
        tbl_addr = 6'(a);
        tbl_data = RW'(d);
        @(posedge clk); #1;
        tbl_we   = 1'b0;
    endtask

    task automatic send_beat(input logic [LANES*DW-1:0] xv, input bit clr);
        bit rdy;
        bit done;
        in_valid = 1'b1;
        x        = xv;
        blk_clr  = clr;
        done     = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            done = rdy;
        end
        if (!done) begin
            bad++;
            total++;
            $display("FAIL send_beat: in_ready stuck low, got 0 expected 1");
        end
        in_valid = 1'b0;
        blk_clr  = 1'b0;
    endtask

    task automatic wait_outputs(input string name, input int n);
        for (int c = 0; c < 200 && oq.size() < n; c++)
            @(negedge clk);
        @(posedge clk); #1;
        check(name, oq.size(), n);
    endtask

    vec_t vecs[11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{-37,    'h4000, -37,   -37};
        vecs[1]  = '{100,    'h0800,  12,    13};
        vecs[2]  = '{-100,   'h0800, -12,   -13};
        vecs[3]  = '{32767,  'hFFFF, 2047,  2047};
        vecs[4]  = '{-32768, 'hFFFF, -2048, -2048};
        vecs[5]  = '{0,      'h1234,  0,     0};
        vecs[6]  = '{1000,   'h2000, 500,   500};
        vecs[7]  = '{-3,     'h2000, -1,    -2};
        vecs[8]  = '{3000,   'h4000, 2047,  2047};
        vecs[9]  = '{-2049,  'h4000, -2048, -2048};
        vecs[10] = '{5,      'h1000,  1,     1};

        rst = 1'b1; in_valid = 1'b0; x = '0; blk_clr = 1'b0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_q",         int'(q == '0), 1);
        check("rst_out_last",  int'(out_last), 0);
        check("rst_in_ready",  int'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity table after reset, latency of two edges including accept.
        oq.delete();
        in_valid = 1'b1; x = pack_all(-37);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_edge1_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_edge2_valid", int'(out_valid), 1);
        for (int k = 0; k < LANES; k++)
            check($sformatf("lat_q_lane%0d", k), lane_q(q, k), -37);
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[v]) begin
            for (int i = 0; i < LANES; i++)
                tbl_write(i, vecs[v].rec);
            oq.delete();
            send_beat(pack_all(vecs[v].x), 1'b1);
            wait_outputs($sformatf("vec%0d_count", v), 1);
            if (oq.size() > 0)
                for (int k = 0; k < LANES; k++)
                    check($sformatf("vec%0d_lane%0d x=%0d", v, k, vecs[v].x),
                          lane_q(oq[0].qv, k), ROUND ? vecs[v].exp_r : vecs[v].exp_t);
        end

        // Block wrap and last flag: positions 0..3 identity, the rest halve.
        for (int i = 0; i < 64; i++)
            tbl_write(i, (i < 4) ? 'h4000 : 'h2000);
        oq.delete();
        for (int b = 0; b < 17; b++)
            send_beat(pack_all(100), b == 0);
        wait_outputs("wrap_count", 17);
        for (int b = 0; b < 17 && b < oq.size(); b++) begin
            check($sformatf("wrap_b%0d_lane0", b), lane_q(oq[b].qv, 0),
                  (b == 0 || b == 16) ? 100 : 50);
            check($sformatf("wrap_b%0d_lane3", b), lane_q(oq[b].qv, 3),
                  (b == 0 || b == 16) ? 100 : 50);
            check($sformatf("wrap_b%0d_last", b), int'(oq[b].last), (b == 15) ? 1 : 0);
        end

        // Block clear on the fifth beat restarts the position.
        oq.delete();
        for (int b = 0; b < 6; b++)
            send_beat(pack_all(100), b == 0 || b == 4);
        wait_outputs("clr_count", 6);
        for (int b = 0; b < 6 && b < oq.size(); b++) begin
            check($sformatf("clr_b%0d_lane0", b), lane_q(oq[b].qv, 0),
                  (b == 0 || b == 4) ? 100 : 50);
            check($sformatf("clr_b%0d_last", b), int'(oq[b].last), 0);
        end

        // Reset with a beat in stage 1 discards it and restores the table.
        oq.delete();
        send_beat(pack_all(77), 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid0", int'(out_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_valid3", int'(out_valid), 0);
        check("midrst_count", oq.size(), 0);

        // Same-edge table write to entry 0 while a pos-0 beat is accepted.
        oq.delete();
        tbl_we = 1'b1; tbl_addr = 6'd0; tbl_data = 16'h2000;
        in_valid = 1'b1; x = pack_all(100);
        @(posedge clk); #1;
        tbl_we = 1'b0; in_valid = 1'b0;
        send_beat(pack_all(100), 1'b1);
        wait_outputs("wr_count", 2);
        if (oq.size() >= 2) begin
            check("wr_b0_lane0", lane_q(oq[0].qv, 0), 100);
            check("wr_b0_lane1", lane_q(oq[0].qv, 1), 100);
            check("wr_b1_lane0", lane_q(oq[1].qv, 0), 50);
            check("wr_b1_lane1", lane_q(oq[1].qv, 1), 100);
        end

        // Backpressure: downstream stalls until both stages fill, then 3 more.
        tbl_write(0, 'h4000);
        oq.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_beat(pack_seq(i), i == 0);
            end
            begin
                logic [LANES*OW-1:0] held;
                bit full;
                full = 1'b0;
                for (int c = 0; c < 20 && !full; c++) begin
                    @(negedge clk);
                    full = !in_ready;
                end
                check("bp_in_ready_low", int'(in_ready), 0);
                check("bp_valid_held", int'(out_valid), 1);
                held = q;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check($sformatf("bp_q_stable%0d", c), int'(q == held), 1);
                    check($sformatf("bp_in_ready%0d", c), int'(in_ready), 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_outputs("bp_count", 8);
        repeat (5) @(posedge clk);
        #1;
        check("bp_no_dup", oq.size(), 8);
        for (int i = 0; i < 8 && i < oq.size(); i++)
            for (int k = 0; k < LANES; k++)
                check($sformatf("bp_b%0d_lane%0d", i, k), lane_q(oq[i].qv, k), seq_x(i, k));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
